// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the systolic PE row and its sequencer/read-out engine.
//   PE_DISABLE / PE_SINGLE / PE_CLEAR : encodings of the 2-bit PE mode bus
//   PE_DATA_W                          : width of one PE result word
//   pe_state_e                         : sequencer FSM state type
// -----------------------------------------------------------------------------
package pe_pkg;

    localparam logic [1:0] PE_DISABLE = 2'b00;
    localparam logic [1:0] PE_SINGLE  = 2'b01;
    localparam logic [1:0] PE_CLEAR   = 2'b10;

    localparam int PE_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_ACC   = 3'd2,
        ST_CAPT  = 3'd3,
        ST_DRAIN = 3'd4
    } pe_state_e;

endpackage

// File: rtl/pe_result_drain.sv
// -----------------------------------------------------------------------------
// pe_result_drain
// Sequences a row of N_PE systolic PEs through clear / accumulate / hold,
// snapshots every PE result and streams the snapshots out over valid/ready.
//
// Optional feature macro: PE_RESULT_DRAIN_SAT_EN
//   defined   : out_data is the snapshot saturated (unsigned) to 16 bits
//   undefined : out_data is the raw 32-bit snapshot
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   start      in   run request, honoured only in IDLE
//   k_len      in   operand beats to accumulate, latched on accepted start
//   mode_out   out  PE mode bus (DISABLE / SINGLE / CLEAR)
//   feed_en    out  feeder must present a new operand beat this cycle
//   pe_result  in   concatenated PE results, PE i at [32i+31:32i]
//   out_valid  out  out_data/out_idx valid
//   out_ready  in   sink accepts the word
//   out_data   out  result word
//   out_idx    out  PE index of the current word
//   busy       out  not IDLE
//   done       out  one-cycle pulse after the last word is accepted
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start, PEs disabled
// ST_CLR   | one cycle of CLEAR to zero the PE accumulators
// ST_ACC   | SINGLE for k_len + N_PE - 1 cycles (operands plus skew flush)
// ST_CAPT  | one cycle, PEs hold, results copied into snapshots
// ST_DRAIN | snapshots streamed out idx 0 .. N_PE-1
// -----------------------------------------------------------------------------
module pe_result_drain
    import pe_pkg::*;
#(
    parameter int N_PE  = 4,
    parameter int IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [15:0]               k_len,
    output logic [1:0]                mode_out,
    output logic                      feed_en,
    input  logic [N_PE*PE_DATA_W-1:0] pe_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PE_DATA_W-1:0]      out_data,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      busy,
    output logic                      done
);

    localparam logic [16:0]      FLUSH    = 17'(N_PE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PE - 1);

    pe_state_e              state_q, state_d;
    logic [15:0]            k_len_q, k_len_d;
    logic [16:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   done_q, done_d;
    logic [PE_DATA_W-1:0]   snap_q [N_PE];
    logic [PE_DATA_W-1:0]   word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_len_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_len_d = k_len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_len_d = k_len;
                    idx_d   = '0;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                // Down-counter terminates at 0, so load L-1. Unused when k_len=0.
                cnt_d   = {1'b0, k_len_q} + FLUSH - 17'd1;
                state_d = (k_len_q == 16'd0) ? ST_CAPT : ST_ACC;
            end
            ST_ACC: begin
                if (cnt_q == 17'd0) begin
                    state_d = ST_CAPT;
                end else begin
                    cnt_d = cnt_q - 17'd1;
                end
            end
            ST_CAPT: begin
                idx_d   = '0;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PE; i++) snap_q[i] <= '0;
        end else if (state_q == ST_CAPT) begin
            for (int i = 0; i < N_PE; i++) snap_q[i] <= pe_result[i*PE_DATA_W +: PE_DATA_W];
        end
    end

    always_comb begin
        mode_out = PE_DISABLE;
        case (state_q)
            ST_CLR:  mode_out = PE_CLEAR;
            ST_ACC:  mode_out = PE_SINGLE;
            default: mode_out = PE_DISABLE;
        endcase
    end

    // Counter runs L-1 .. 0; the first k_len of those cycles are cnt >= N_PE-1.
    assign feed_en   = (state_q == ST_ACC) && (cnt_q >= FLUSH);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DRAIN);
    assign out_idx   = idx_q;
    assign done      = done_q;
    assign word      = snap_q[idx_q];

`ifdef PE_RESULT_DRAIN_SAT_EN
    assign out_data = (word > 32'h0000_FFFF) ? 32'h0000_FFFF : word;
`else
    assign out_data = word;
`endif

endmodule
